// File: rtl/axi2mem_wr_burst_ctrl.sv
// AXI4 write-burst sequencer for the axi2mem bridge.
// Takes one AW burst at a time and streams each W beat straight through as a
// single-word write on the TCDM-style memory port. It generates the per-beat
// address for FIXED, INCR and WRAP bursts and issues one B response per burst.
module axi2mem_wr_burst_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // AW channel
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic [7:0]              aw_len_i,
  input  logic [2:0]              aw_size_i,
  input  logic [1:0]              aw_burst_i,
  input  logic [ID_WIDTH-1:0]     aw_id_i,
  // W channel
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  input  logic [DATA_WIDTH-1:0]   w_data_i,
  input  logic [DATA_WIDTH/8-1:0] w_strb_i,
  input  logic                    w_last_i,
  // B channel
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  output logic [ID_WIDTH-1:0]     b_id_o,
  output logic [1:0]              b_resp_o,
  // Memory port
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  output logic [ADDR_WIDTH-1:0]   mem_add_o,
  output logic                    mem_wen_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o
);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
  logic [7:0]              len_q,   len_d;
  logic [2:0]              size_q,  size_d;
  logic [1:0]              burst_q, burst_d;
  logic [ID_WIDTH-1:0]     id_q,    id_d;
  logic [7:0]              cnt_q,   cnt_d;
  logic                    err_q,   err_d;

  logic [ADDR_WIDTH-1:0]   addr_step;
  logic [ADDR_WIDTH-1:0]   wrap_size;
  logic [ADDR_WIDTH-1:0]   wrap_mask;
  logic [ADDR_WIDTH-1:0]   addr_inc;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic                    wrap_len_ok;
  logic                    beat_fire;
  logic                    final_beat;

  // Only power-of-two beat counts 2/4/8/16 form a legal WRAP window.
  assign wrap_len_ok = (aw_len_i == 8'd1) || (aw_len_i == 8'd3) ||
                       (aw_len_i == 8'd7) || (aw_len_i == 8'd15);

  // W data is passed through combinationally; only the address is registered.
  assign mem_add_o   = addr_q;
  assign mem_be_o    = w_strb_i;
  assign mem_wdata_o = w_data_i;
  assign b_id_o      = id_q;

  assign beat_fire   = (state_q == BURST) && w_valid_i && mem_gnt_i;
  assign final_beat  = (cnt_q == len_q);

  // Address of the beat after the current one, by (effective) burst type.
  always_comb begin
    addr_step = ADDR_WIDTH'(1) << size_q;
    wrap_size = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q;
    wrap_mask = wrap_size - ADDR_WIDTH'(1);
    addr_inc  = addr_q + addr_step;
    case (burst_q)
      BURST_FIXED: addr_next = addr_q;
      BURST_WRAP:  addr_next = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
      default:     addr_next = addr_inc;
    endcase
  end

  // Next-state logic, burst bookkeeping and handshake outputs.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    b_resp_o   = RESP_OKAY;
    mem_req_o  = 1'b0;
    mem_wen_o  = 1'b1;

    case (state_q)
      IDLE: begin
        aw_ready_o = 1'b1;
        if (aw_valid_i) begin
          addr_d  = aw_addr_i;
          len_d   = aw_len_i;
          size_d  = aw_size_i;
          id_d    = aw_id_i;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
          // Reserved encoding and illegal WRAP lengths fall back to INCR;
          // an illegal WRAP length is reported as SLVERR.
          case (aw_burst_i)
            BURST_FIXED: burst_d = BURST_FIXED;
            BURST_WRAP: begin
              if (wrap_len_ok) begin
                burst_d = BURST_WRAP;
              end else begin
                burst_d = BURST_INCR;
                err_d   = 1'b1;
              end
            end
            default:     burst_d = BURST_INCR;
          endcase
          state_d = BURST;
        end
      end

      BURST: begin
        mem_req_o = w_valid_i;
        mem_wen_o = 1'b0;
        w_ready_o = mem_gnt_i;
        if (beat_fire) begin
          cnt_d  = cnt_q + 8'd1;
          addr_d = addr_next;
          // Termination is by count; a misplaced WLAST only flags an error.
          if (final_beat != w_last_i) begin
            err_d = 1'b1;
          end
          if (final_beat) begin
            state_d = RESP;
          end
        end
      end

      RESP: begin
        b_valid_o = 1'b1;
        b_resp_o  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (b_ready_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and burst-context registers; reset drops any partial burst.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= BURST_FIXED;
      id_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule
